// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: in-order fixed-latency read pipeline over a
// word-addressed program memory, with a program-load port and an optional LFSR grant throttle.
module instr_mem_responder #(
    parameter int          MEM_WORDS       = 1024,
    parameter logic [31:0] BASE_ADDR       = 32'h0000_0000,
    parameter int          LATENCY         = 1,
    parameter int          MAX_OUTSTANDING = 1,
    parameter logic [7:0]  LFSR_SEED       = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_req,
    input  logic [31:0] instr_addr,
    output logic        instr_gnt,
    output logic [31:0] instr_rdata,
    output logic        instr_err,
    output logic        instr_valid,
    input  logic        throttle_en,
    input  logic        load_we,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_wdata
);

    localparam int          AW      = $clog2(MEM_WORDS);
    localparam int          IW      = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [31:0] WORDS32 = 32'(MEM_WORDS);
    localparam logic [31:0] MAX32   = 32'(MAX_OUTSTANDING);

    logic [31:0] mem [MEM_WORDS];

    logic [31:0] rd_off, rd_idx, rd_data;
    logic        rd_err;
    logic [31:0] ld_off, ld_idx;
    logic        ld_ok;

    logic [LATENCY-1:0] pv_q, pv_d;
    logic [LATENCY-1:0] pe_q, pe_d;
    logic [31:0]        pd_q [LATENCY];
    logic [31:0]        pd_d [LATENCY];

    logic [IW-1:0] inflight_q, inflight_d, retire_cnt;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          gnt_base, throttle_hit, accept;

    // Unsigned 32-bit offset: addresses below BASE_ADDR wrap high and are also caught explicitly.
    assign rd_off  = instr_addr - BASE_ADDR;
    assign rd_idx  = rd_off >> 2;
    assign rd_err  = (instr_addr[1:0] != 2'b00) | (instr_addr < BASE_ADDR) | (rd_idx >= WORDS32);
    assign rd_data = rd_err ? 32'h0 : mem[rd_idx[AW-1:0]];

    assign ld_off = load_addr - BASE_ADDR;
    assign ld_idx = ld_off >> 2;
    assign ld_ok  = load_we & (load_addr >= BASE_ADDR) & (ld_idx < WORDS32);

    // Write lands at the clock edge, so a same-cycle read still sees the old word.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_idx[AW-1:0]] <= load_wdata;
        end
    end

    // A slot retiring this cycle may be reused by a same-cycle accept.
    assign retire_cnt   = inflight_q - IW'(instr_valid);
    assign gnt_base     = 32'(retire_cnt) < MAX32;
    assign throttle_hit = throttle_en & (lfsr_q[1:0] == 2'b00);
    assign instr_gnt    = gnt_base & ~throttle_hit;
    assign accept       = instr_req & instr_gnt;

    always_comb begin
        pv_d[0] = accept;
        pe_d[0] = rd_err;
        pd_d[0] = rd_data;
        for (int i = 1; i < LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pe_d[i] = pe_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
        inflight_d = inflight_q + IW'(accept) - IW'(instr_valid);
        lfsr_d     = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv_q <= '0;
            pe_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                pd_q[i] <= '0;
            end
            inflight_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            pv_q       <= pv_d;
            pe_q       <= pe_d;
            pd_q       <= pd_d;
            inflight_q <= inflight_d;
            lfsr_q     <= lfsr_d;
        end
    end

    assign instr_valid = pv_q[LATENCY-1];
    assign instr_err   = pe_q[LATENCY-1];
    assign instr_rdata = pd_q[LATENCY-1];

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three configurations share one stimulus stream and are each
// checked every cycle against a transaction-level model (memory array + response queue).
module tb_instr_mem_responder;

    localparam int          WORDS = 64;
    localparam logic [31:0] BASE  = 32'h0000_0100;
    localparam logic [7:0]  SEED  = 8'hA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        instr_req;
    logic [31:0] instr_addr;
    logic        throttle_en;
    logic        load_we;
    logic [31:0] load_addr;
    logic [31:0] load_wdata;

    logic [2:0]  gnt_w, valid_w, err_w;
    logic [31:0] rdata_w [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(1), .MAX_OUTSTANDING(1),
                          .LFSR_SEED(SEED)) u_a (
        .clk(clk), .reset_n(reset_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_gnt(gnt_w[0]), .instr_rdata(rdata_w[0]), .instr_err(err_w[0]),
        .instr_valid(valid_w[0]), .throttle_en(throttle_en), .load_we(load_we),
        .load_addr(load_addr), .load_wdata(load_wdata));

    instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(3), .MAX_OUTSTANDING(2),
                          .LFSR_SEED(SEED)) u_b (
        .clk(clk), .reset_n(reset_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_gnt(gnt_w[1]), .instr_rdata(rdata_w[1]), .instr_err(err_w[1]),
        .instr_valid(valid_w[1]), .throttle_en(throttle_en), .load_we(load_we),
        .load_addr(load_addr), .load_wdata(load_wdata));

    instr_mem_responder #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .LATENCY(4), .MAX_OUTSTANDING(2),
                          .LFSR_SEED(SEED)) u_c (
        .clk(clk), .reset_n(reset_n), .instr_req(instr_req), .instr_addr(instr_addr),
        .instr_gnt(gnt_w[2]), .instr_rdata(rdata_w[2]), .instr_err(err_w[2]),
        .instr_valid(valid_w[2]), .throttle_en(throttle_en), .load_we(load_we),
        .load_addr(load_addr), .load_wdata(load_wdata));

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 3 : 4);
    endfunction

    function automatic int max_of(input int k);
        return (k == 0) ? 1 : 2;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: memory contents, per-configuration queue of {due_cycle, err, data}.
    logic [31:0] mem_m [WORDS];
    logic [64:0] exp_q [3][$];
    logic [31:0] cyc = 0;
    logic [7:0]  lfsr_m = SEED;
    int          thr_cycles = 0;
    int          thr_low    = 0;

    function automatic logic [32:0] model_read(input logic [31:0] a);
        longint off;
        off = longint'(a) - longint'(BASE);
        if (a[1:0] != 2'b00 || off < 0 || (off / 4) >= WORDS) return {1'b1, 32'h0};
        return {1'b0, mem_m[int'(off / 4)]};
    endfunction

    always @(negedge clk) begin : monitor
        logic        retiring, exp_gnt;
        logic [32:0] rd;
        longint      loff;
        cyc = cyc + 1;
        if (!reset_n) begin
            for (int k = 0; k < 3; k++) begin
                chk($sformatf("rst_valid[%0d]", k), 32'(valid_w[k]), 32'h0);
                chk($sformatf("rst_rdata[%0d]", k), rdata_w[k], 32'h0);
                chk($sformatf("rst_err[%0d]", k), 32'(err_w[k]), 32'h0);
                exp_q[k].delete();
            end
            lfsr_m = SEED;
        end else begin
            if (throttle_en) begin
                thr_cycles++;
                if (!gnt_w[0]) thr_low++;
            end
            for (int k = 0; k < 3; k++) begin
                retiring = (exp_q[k].size() > 0) && (exp_q[k][0][64:33] == cyc);
                exp_gnt  = ((exp_q[k].size() - int'(retiring)) < max_of(k)) &&
                           !(throttle_en && lfsr_m[1:0] == 2'b00);
                chk($sformatf("valid[%0d]@%0d", k, cyc), 32'(valid_w[k]), 32'(retiring));
                if (retiring) begin
                    chk($sformatf("err[%0d]@%0d", k, cyc), 32'(err_w[k]), 32'(exp_q[k][0][32]));
                    chk($sformatf("rdata[%0d]@%0d", k, cyc), rdata_w[k], exp_q[k][0][31:0]);
                    void'(exp_q[k].pop_front());
                end
                chk($sformatf("gnt[%0d]@%0d", k, cyc), 32'(gnt_w[k]), 32'(exp_gnt));
                if (instr_req && exp_gnt) begin
                    rd = model_read(instr_addr);
                    exp_q[k].push_back({cyc + 32'(lat_of(k)), rd});
                end
            end
            loff = longint'(load_addr) - longint'(BASE);
            if (load_we && loff >= 0 && (loff / 4) < WORDS) mem_m[int'(loff / 4)] = load_wdata;
            lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
        end
    end

    task automatic drive(input logic r, input logic [31:0] a, input logic we,
                         input logic [31:0] la, input logic [31:0] wd);
        instr_req  = r;
        instr_addr = a;
        load_we    = we;
        load_addr  = la;
        load_wdata = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin : stimulus
        logic [31:0] t3_addr [5];
        logic [31:0] a;
        t3_addr = '{BASE + 32'd2, BASE + 32'(4 * WORDS), 32'h0000_0000, 32'hFFFF_FFFC, BASE + 32'd4};
        reset_n     = 1'b0;
        throttle_en = 1'b0;
        instr_req   = 1'b0;
        instr_addr  = '0;
        load_we     = 1'b0;
        load_addr   = '0;
        load_wdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_inflight_a", 32'(u_a.inflight_q), 32'h0);
        chk("rst_inflight_c", 32'(u_c.inflight_q), 32'h0);
        reset_n = 1'b1;

        // Preload every word, then the T1 program words.
        for (int i = 0; i < WORDS; i++) drive(1'b0, 32'h0, 1'b1, BASE + 32'(4 * i), $urandom);
        drive(1'b0, 32'h0, 1'b1, BASE + 32'd0,  32'h13);
        drive(1'b0, 32'h0, 1'b1, BASE + 32'd4,  32'h93);
        drive(1'b0, 32'h0, 1'b1, BASE + 32'd8,  32'h113);
        drive(1'b0, 32'h0, 1'b1, BASE + 32'd12, 32'h193);

        // T1: back-to-back fetches.
        for (int i = 0; i < 4; i++) drive(1'b1, BASE + 32'(4 * i), 1'b0, 32'h0, 32'h0);
        idle(8);

        // T2: request held so outstanding limits shape the grant pattern.
        for (int i = 0; i < 6; i++) drive(1'b1, BASE + 32'(4 * (i % 3)), 1'b0, 32'h0, 32'h0);
        idle(8);

        // T3: error addresses plus dropped out-of-range loads, then reads of the edge words.
        for (int j = 0; j < 5; j++) for (int i = 0; i < 5; i++) drive(1'b1, t3_addr[j], 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b1, BASE + 32'(4 * WORDS), 32'hFFFF_FFFF);
        drive(1'b0, 32'h0, 1'b1, BASE - 32'd4, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) drive(1'b1, BASE, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) drive(1'b1, BASE + 32'(4 * (WORDS - 1)), 1'b0, 32'h0, 32'h0);
        idle(8);

        // T4: same-cycle read and load of one word, then a re-read.
        drive(1'b1, BASE + 32'h10, 1'b1, BASE + 32'h10, 32'hDEAD_BEEF);
        idle(6);
        drive(1'b1, BASE + 32'h10, 1'b0, 32'h0, 32'h0);
        idle(8);

        // T5: throttled random traffic with concurrent loads.
        throttle_en = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 15) == 0) a = BASE + 32'(4 * WORDS) + 32'(4 * $urandom_range(0, 7));
            else a = BASE + 32'(4 * $urandom_range(0, WORDS - 1));
            drive($urandom_range(0, 9) != 0, a, $urandom_range(0, 3) == 0,
                  BASE + 32'(4 * $urandom_range(0, WORDS - 1)), $urandom);
        end
        throttle_en = 1'b0;
        idle(8);
        chk("t5_throttle_rate", 32'(thr_low >= 50 && thr_low <= 100), 32'h1);
        chk("t5_throttle_cycles", 32'(thr_cycles), 32'd300);

        // T6: reset with responses still pending.
        drive(1'b1, BASE + 32'd8, 1'b0, 32'h0, 32'h0);
        drive(1'b1, BASE + 32'd12, 1'b0, 32'h0, 32'h0);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0);
        reset_n = 1'b0;
        idle(3);
        reset_n = 1'b1;
        chk("t6_inflight_a", 32'(u_a.inflight_q), 32'h0);
        chk("t6_inflight_b", 32'(u_b.inflight_q), 32'h0);
        chk("t6_inflight_c", 32'(u_c.inflight_q), 32'h0);
        idle(6);
        drive(1'b1, BASE + 32'd12, 1'b0, 32'h0, 32'h0);
        idle(8);

        for (int k = 0; k < 3; k++) chk($sformatf("drain[%0d]", k), 32'(exp_q[k].size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
